// File: rtl/pipe_stage_pkg.sv
// Shared types and default widths for the skid-buffered pipeline stage.
// Holds the occupancy state enum and the default payload widths.
package pipe_stage_pkg;

   localparam int DEF_DATAW = 128;
   localparam int DEF_CTRLW = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_e;

endpackage

// File: rtl/pipe_reg_en.sv
// Width-parameterised register with load enable and synchronous
// active-low reset that clears the contents to zero.
module pipe_reg_en #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Load on enable, clear while reset is held low
   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline stage with registered ready/valid.
// A main register drives the outputs; a skid register catches the beat
// that arrives while the downstream is stalled. Flush drops all held
// beats and zeroes the stored control so a bubble has no side effects,
// while the data payload is left untouched.
// Optional feature: define PIPE_SKID_STALL_CNT_EN to add a 32-bit
// stall_cnt output counting cycles with out_valid=1 and out_ready=0.
module pipe_skid_stage
   import pipe_stage_pkg::*;
#(
   parameter int DATAW = DEF_DATAW,
   parameter int CTRLW = DEF_CTRLW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATAW-1:0] in_data,
   input  logic [CTRLW-1:0] in_ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_data,
   output logic [CTRLW-1:0] out_ctrl
`ifdef PIPE_SKID_STALL_CNT_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);

   stage_state_e     state;
   stage_state_e     next_state;
   logic             in_ready_q;
   logic             out_valid_q;

   logic             xfer_in;
   logic             xfer_out;
   logic             load_main_in;
   logic             load_main_skid;
   logic             load_skid;

   logic             main_en;
   logic             main_ctrl_en;
   logic             skid_ctrl_en;
   logic [DATAW-1:0] main_data_d;
   logic [CTRLW-1:0] main_ctrl_d;
   logic [CTRLW-1:0] skid_ctrl_d;

   logic [DATAW-1:0] main_data;
   logic [CTRLW-1:0] main_ctrl;
   logic [DATAW-1:0] skid_data;
   logic [CTRLW-1:0] skid_ctrl;

   assign xfer_in  = in_valid & in_ready_q;
   assign xfer_out = out_valid_q & out_ready;

   // Next occupancy and which register loads from where; flush wins
   always_comb begin
      next_state     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (xfer_in) begin
               next_state   = ONE;
               load_main_in = 1'b1;
            end
         end
         ONE: begin
            if (xfer_in && xfer_out) begin
               load_main_in = 1'b1;
            end else if (xfer_in) begin
               next_state = FULL;
               load_skid  = 1'b1;
            end else if (xfer_out) begin
               next_state = EMPTY;
            end
         end
         FULL: begin
            if (xfer_out) begin
               next_state     = ONE;
               load_main_skid = 1'b1;
            end
         end
         default: begin
            next_state = EMPTY;
         end
      endcase
      if (flush) begin
         next_state     = EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   // Register input muxes: ctrl registers also load zero on flush
   always_comb begin
      main_en      = load_main_in | load_main_skid;
      main_ctrl_en = main_en | flush;
      skid_ctrl_en = load_skid | flush;
      main_data_d  = load_main_skid ? skid_data : in_data;
      main_ctrl_d  = flush ? '0 : (load_main_skid ? skid_ctrl : in_ctrl);
      skid_ctrl_d  = flush ? '0 : in_ctrl;
   end

   // Occupancy state with registered ready and valid derived from it
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= EMPTY;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state       <= next_state;
         in_ready_q  <= (next_state != FULL);
         out_valid_q <= (next_state != EMPTY);
      end
   end

   pipe_reg_en #(.W(DATAW)) u_main_data (
      .clk (clk),
      .rst (rst),
      .en  (main_en),
      .d   (main_data_d),
      .q   (main_data)
   );

   pipe_reg_en #(.W(CTRLW)) u_main_ctrl (
      .clk (clk),
      .rst (rst),
      .en  (main_ctrl_en),
      .d   (main_ctrl_d),
      .q   (main_ctrl)
   );

   pipe_reg_en #(.W(DATAW)) u_skid_data (
      .clk (clk),
      .rst (rst),
      .en  (load_skid),
      .d   (in_data),
      .q   (skid_data)
   );

   pipe_reg_en #(.W(CTRLW)) u_skid_ctrl (
      .clk (clk),
      .rst (rst),
      .en  (skid_ctrl_en),
      .d   (skid_ctrl_d),
      .q   (skid_ctrl)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_data;
   assign out_ctrl  = out_valid_q ? main_ctrl : '0;

`ifdef PIPE_SKID_STALL_CNT_EN
   // Count stalled cycles; wraps naturally, survives flush
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (out_valid_q && !out_ready) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage: directed scenarios followed by random
// traffic, all checked against a queue-based model of a two-deep FIFO
// stage with registered ready/valid.
module tb_pipe_skid_stage;

   localparam int DW = 32;
   localparam int CW = 8;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
`ifdef PIPE_SKID_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   beat_t         mq[$];
   logic          m_ready;
   logic [DW-1:0] m_last;
   logic [31:0]   m_cnt;

   pipe_skid_stage #(.DATAW(DW), .CTRLW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl)
`ifdef PIPE_SKID_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      chk("in_ready", 64'(in_ready), 64'(m_ready));
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("out_data", 64'(out_data), 64'((mq.size() > 0) ? mq[0].d : m_last));
      chk("out_ctrl", 64'(out_ctrl), 64'((mq.size() > 0) ? mq[0].c : '0));
`ifdef PIPE_SKID_STALL_CNT_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
`endif
   endtask

   // FIFO-level model of one clock edge using the inputs just applied
   task automatic modelEdge();
      logic xin;
      logic xout;
      if (!rst) begin
         mq.delete();
         m_ready = 1'b0;
         m_last  = '0;
         m_cnt   = '0;
      end else begin
         if (mq.size() > 0 && !out_ready) m_cnt = m_cnt + 32'd1;
         if (flush) begin
            mq.delete();
            m_ready = 1'b1;
         end else begin
            xin  = in_valid && m_ready;
            xout = (mq.size() > 0) && out_ready;
            if (xout) void'(mq.pop_front());
            if (xin) mq.push_back('{d: in_data, c: in_ctrl});
            m_ready = (mq.size() < 2);
         end
         if (mq.size() > 0) m_last = mq[0].d;
      end
   endtask

   // Drive one cycle of inputs, check outputs, then advance one edge
   task automatic applyStimulus(input logic r, input logic fl, input logic iv,
                                input logic [DW-1:0] d, input logic [CW-1:0] c,
                                input logic ordy);
      rst       = r;
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      #1;
      checkOutput();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hA5;
      in_ctrl = 8'h3C; out_ready = 1'b0;
      m_ready = 1'b0; m_last = '0; m_cnt = '0;
      @(posedge clk);
      modelEdge();
      #1;

      // Reset held with a pending beat, then release
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hA5, 8'h3C, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
      chk("ready_after_rst", 64'(in_ready), 64'd1);

      // Streaming beats 1..8 with downstream always ready
      for (int i = 1; i <= 8; i++)
         applyStimulus(1'b1, 1'b0, 1'b1, DW'(i), CW'(8'h80 + i), 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1);

      // Backpressure: two beats fill the stage, then drain
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h11, 8'h01, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h22, 8'h02, 1'b0);
      chk("bp_ready_low", 64'(in_ready), 64'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h99, 8'h09, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1);

      // Flush from FULL with a beat offered in the same cycle
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h33, 8'hF3, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h44, 8'hF4, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h55, 8'hF5, 1'b0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_ctrl", 64'(out_ctrl), 64'd0);
      chk("flush_data_kept", 64'(out_data), 64'h33);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1);

      // Simultaneous in and out while holding one beat
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h5A, 8'h15, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h66, 8'h16, 1'b1);
      chk("simul_data", 64'(out_data), 64'h66);
      chk("simul_ready", 64'(in_ready), 64'd1);

`ifdef PIPE_SKID_STALL_CNT_EN
      // Stall counter: 5 stalled cycles, survives flush, cleared by reset
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h77, 8'h07, 1'b0);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
      chk("cnt_five", 64'(stall_cnt), 64'd5);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 8'h0, 1'b1);
      chk("cnt_after_flush", 64'(stall_cnt), 64'd5);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1);
      chk("cnt_after_rst", 64'(stall_cnt), 64'd0);
`endif

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 600; i++)
         applyStimulus(($urandom_range(0, 49) != 0),
                        ($urandom_range(0, 19) == 0),
                        1'($urandom_range(0, 1)),
                        DW'($urandom),
                        CW'($urandom),
                        ($urandom_range(0, 3) != 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
